// File: rtl/pio_key_in_if.sv
// rtl/pio_key_in_if.sv - Avalon-MM slave bus bundle for the key input PIO
//
// Purpose: groups the register-access signals and the interrupt line of
//          pio_key_in so they travel as one port.
// Signals: address[1:0]      word address
//          chipselect        slave select
//          read_n / write_n  active-low strobes
//          writedata[W-1:0]  write data
//          readdata[W-1:0]   registered read data (slave drives)
//          irq               level interrupt, active-high (slave drives)
interface pio_key_in_if #(
    parameter int WIDTH = 4
) ();
    logic [1:0]       address;
    logic             chipselect;
    logic             read_n;
    logic             write_n;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;
    logic             irq;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/pio_key_in.sv
// rtl/pio_key_in.sv - active-low key input PIO with falling-edge capture and irq
//
// Purpose: synchronizes active-low key inputs, optionally debounces them,
//          latches falling edges into a write-1-to-clear capture register
//          and raises a masked, registered level interrupt.
// Ports:   clk        system clock, rising edge
//          reset_n    asynchronous active-low reset
//          in_port    asynchronous key inputs, pressed = 0
//          bus        pio_key_in_if.slave register port
//                     read  map: 0 = cond, 1 = 0, 2 = irqmask, 3 = edge_capture
//                     write map: 2 = irqmask, 3 = edge_capture W1C, 0/1 ignored
// Config:  PIO_KEY_IN_DEBOUNCE_EN adds a per-bit stability counter of
//          DEBOUNCE_CYCLES clocks between the synchronizer and edge detect.
module pio_key_in #(
    parameter int          WIDTH           = 4,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    pio_key_in_if.slave      bus
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] cond_prev_q, cond_prev_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0] readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] cond;
    logic [WIDTH-1:0] edge_det;
    logic             rd_en;
    logic             wr_en;

`ifdef PIO_KEY_IN_DEBOUNCE_EN
    localparam logic [15:0] CNT_LAST = DEBOUNCE_CYCLES - 16'd1;

    logic [WIDTH-1:0]       cond_q, cond_d;
    logic [WIDTH-1:0][15:0] cnt_q, cnt_d;

    // A bit only follows the synchronizer after it has disagreed with the
    // current debounced value for DEBOUNCE_CYCLES back-to-back clocks; any
    // agreement in between restarts the count.
    always_comb begin
        cond_d = cond_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] != cond_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    cond_d[i] = sync2_q[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cond_q <= '1;
            cnt_q  <= '0;
        end else begin
            cond_q <= cond_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cond = cond_q;
`else
    // The debounce length has no effect in this build.
    if (DEBOUNCE_CYCLES == 16'd0) begin : g_debounce_ignored
    end

    assign cond = sync2_q;
`endif

    assign rd_en    = bus.chipselect & ~bus.read_n;
    assign wr_en    = bus.chipselect & ~bus.write_n;
    assign edge_det = cond_prev_q & ~cond;

    always_comb begin
        sync1_d        = in_port;
        sync2_d        = sync1_q;
        cond_prev_d    = cond;
        irqmask_d      = irqmask_q;
        edge_capture_d = edge_capture_q;
        readdata_d     = readdata_q;

        if (wr_en) begin
            case (bus.address)
                2'd2:    irqmask_d      = bus.writedata;
                2'd3:    edge_capture_d = edge_capture_q & ~bus.writedata;
                default: ;
            endcase
        end
        // OR-ing the new edges in after the clear lets a coincident edge win.
        edge_capture_d = edge_capture_d | edge_det;

        if (rd_en) begin
            case (bus.address)
                2'd0:    readdata_d = cond;
                2'd1:    readdata_d = '0;
                2'd2:    readdata_d = irqmask_q;
                default: readdata_d = edge_capture_q;
            endcase
        end

        irq_d = |(edge_capture_q & irqmask_q);
    end

    // Input-side flops reset high so the first cycles after reset look like
    // released keys and produce no falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q        <= '1;
            sync2_q        <= '1;
            cond_prev_q    <= '1;
            irqmask_q      <= '0;
            edge_capture_q <= '0;
            readdata_q     <= '0;
            irq_q          <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            cond_prev_q    <= cond_prev_d;
            irqmask_q      <= irqmask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
            irq_q          <= irq_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_pio_key_in.sv
// tb/tb_pio_key_in.sv - scoreboard testbench for pio_key_in
module tb_pio_key_in;

`ifdef PIO_KEY_IN_DEBOUNCE_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in_port = 4'hF;

    int         checks = 0;
    int         failures = 0;
    logic [3:0] exp_q[$];
    logic [3:0] obs;
    logic [3:0] e;

    pio_key_in_if #(.WIDTH(4)) bus ();

    pio_key_in #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (16'd8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [3:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        @(posedge clk);
        #1;
        d = bus.readdata;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_port = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.readdata !== 4'h0) begin
            failures++; $display("FAIL reset_readdata got=%h exp=0", bus.readdata);
        end
        checks++;
        if (bus.irq !== 1'b0) begin
            failures++; $display("FAIL reset_irq got=%b exp=0", bus.irq);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        exp_q.push_back(4'h0);
        bus_read(2'd3, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL reset_edge_capture got=%h exp=%h", obs, e);
        end
        exp_q.push_back(4'hF);
        bus_read(2'd0, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL reset_cond got=%h exp=%h", obs, e);
        end
        exp_q.push_back(4'h0);
        bus_read(2'd2, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL reset_irqmask got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_edge_irq();
        bus_write(2'd2, 4'h2);
        exp_q.push_back(4'h2);
        bus_read(2'd2, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL irqmask_rd got=%h exp=%h", obs, e);
        end
        @(negedge clk);
        in_port = 4'hD;
        repeat (LAT - 1) @(posedge clk);
        #1;
        checks++;
        if (dut.edge_capture_q !== 4'h0) begin
            failures++; $display("FAIL edge_early got=%h exp=0", dut.edge_capture_q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dut.edge_capture_q !== 4'h2) begin
            failures++; $display("FAIL edge_latency got=%h exp=2", dut.edge_capture_q);
        end
        checks++;
        if (bus.irq !== 1'b0) begin
            failures++; $display("FAIL irq_early got=%b exp=0", bus.irq);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.irq !== 1'b1) begin
            failures++; $display("FAIL irq_assert got=%b exp=1", bus.irq);
        end
        exp_q.push_back(4'hD);
        bus_read(2'd0, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL cond_rd got=%h exp=%h", obs, e);
        end
        exp_q.push_back(4'h0);
        bus_read(2'd1, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL addr1_rd got=%h exp=%h", obs, e);
        end
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(4'h2);
            bus_read(2'd3, obs);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++; $display("FAIL capture_rd%0d got=%h exp=%h", k, obs, e);
            end
        end
    endtask

    task automatic test_clear();
        bus_write(2'd0, 4'h0);
        bus_write(2'd1, 4'hF);
        bus_write(2'd3, 4'h2);
        checks++;
        if (dut.edge_capture_q !== 4'h0) begin
            failures++; $display("FAIL clear_capture got=%h exp=0", dut.edge_capture_q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.irq !== 1'b0) begin
            failures++; $display("FAIL clear_irq got=%b exp=0", bus.irq);
        end
        @(negedge clk);
        in_port = 4'hF;
        repeat (LAT + 3) @(posedge clk);
        exp_q.push_back(4'h0);
        bus_read(2'd3, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL rising_no_capture got=%h exp=%h", obs, e);
        end
        exp_q.push_back(4'h2);
        bus_read(2'd2, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL ignored_writes got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_set_wins();
        @(negedge clk);
        in_port = 4'hE;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        bus.address    = 2'd3;
        bus.writedata  = 4'h1;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (dut.edge_capture_q !== 4'h1) begin
            failures++; $display("FAIL set_wins got=%h exp=1", dut.edge_capture_q);
        end
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus_write(2'd3, 4'h1);
        exp_q.push_back(4'h0);
        bus_read(2'd3, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL plain_clear got=%h exp=%h", obs, e);
        end
        @(negedge clk);
        in_port = 4'hF;
        repeat (LAT + 3) @(posedge clk);
    endtask

    task automatic test_mask();
        bus_write(2'd2, 4'h0);
        @(negedge clk);
        in_port = 4'h7;
        repeat (LAT + 3) @(posedge clk);
        #1;
        checks++;
        if (bus.irq !== 1'b0) begin
            failures++; $display("FAIL masked_irq got=%b exp=0", bus.irq);
        end
        exp_q.push_back(4'h8);
        bus_read(2'd3, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL masked_capture got=%h exp=%h", obs, e);
        end
        bus_write(2'd2, 4'h8);
        checks++;
        if (bus.irq !== 1'b0) begin
            failures++; $display("FAIL unmask_irq_reg got=%b exp=0", bus.irq);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.irq !== 1'b1) begin
            failures++; $display("FAIL unmask_irq got=%b exp=1", bus.irq);
        end
        @(negedge clk);
        in_port = 4'hF;
        repeat (LAT + 3) @(posedge clk);
        bus_write(2'd3, 4'hF);
        bus_write(2'd2, 4'h0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_port = 4'hE;
        @(negedge clk);
        in_port = 4'hC;
        repeat (LAT + 3) @(posedge clk);
        exp_q.push_back(4'h3);
        bus_read(2'd3, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL b2b_capture got=%h exp=%h", obs, e);
        end
        bus_write(2'd3, 4'h1);
        exp_q.push_back(4'h2);
        bus_read(2'd3, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL selective_clear got=%h exp=%h", obs, e);
        end
        @(negedge clk);
        in_port = 4'hF;
        repeat (LAT + 3) @(posedge clk);
        bus_write(2'd3, 4'hF);
    endtask

`ifdef PIO_KEY_IN_DEBOUNCE_EN
    task automatic test_debounce();
        @(negedge clk);
        in_port = 4'hD;
        repeat (5) @(negedge clk);
        in_port = 4'hF;
        repeat (20) @(posedge clk);
        exp_q.push_back(4'h0);
        bus_read(2'd3, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL glitch_capture got=%h exp=%h", obs, e);
        end
        @(negedge clk);
        in_port = 4'hD;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (dut.edge_capture_q !== 4'h0) begin
            failures++; $display("FAIL debounce_early got=%h exp=0", dut.edge_capture_q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dut.edge_capture_q !== 4'h2) begin
            failures++; $display("FAIL debounce_latency got=%h exp=2", dut.edge_capture_q);
        end
        repeat (9) @(negedge clk);
        in_port = 4'hF;
        repeat (20) @(posedge clk);
    endtask
`endif

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        bus.write_n    = 1'b1;
        bus.writedata  = 4'h0;
        test_reset();
        test_edge_irq();
        test_clear();
        test_set_wins();
        test_mask();
        test_back_to_back();
`ifdef PIO_KEY_IN_DEBOUNCE_EN
        test_debounce();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
